// File: rtl/issue_dispatch_queue_pkg.sv
// Shared issue-path types: status bundle, ROB index, queue entry, and the age and wakeup helpers
// used by the dispatch queue and the issue banks.
package issue_dispatch_queue_pkg;

    localparam int unsigned PREG_WIDTH       = 6;
    localparam int unsigned WB_SIZE          = 2;
    localparam int unsigned ROB_IDX_WIDTH    = 5;
    localparam int unsigned ISSUE_DATA_WIDTH = 32;

    typedef struct packed {
        logic                     dir;
        logic [ROB_IDX_WIDTH-1:0] idx;
    } rob_idx_t;

    typedef struct packed {
        logic [PREG_WIDTH-1:0] rs1;
        logic                  rs1v;
        logic [PREG_WIDTH-1:0] rs2;
        logic                  rs2v;
        logic [PREG_WIDTH-1:0] rd;
        logic                  we;
        rob_idx_t              rob_idx;
    } issue_status_t;

    typedef struct packed {
        issue_status_t               status;
        logic [ISSUE_DATA_WIDTH-1:0] data;
    } issue_queue_entry_t;

    // True when entry is strictly older than point; the dir bit flips on every ROB wrap.
    function automatic logic is_older(rob_idx_t entry, rob_idx_t point);
        return (entry.dir ^ point.dir) ^ (point.idx > entry.idx);
    endfunction

    function automatic issue_status_t apply_wakeup(
        issue_status_t                         s,
        logic [WB_SIZE-1:0]                    en,
        logic [WB_SIZE-1:0]                    we,
        logic [WB_SIZE-1:0][PREG_WIDTH-1:0]    rd
    );
        issue_status_t r;
        r = s;
        for (int i = 0; i < WB_SIZE; i++) begin
            if (en[i] && we[i]) begin
                if (rd[i] == s.rs1) r.rs1v = 1'b1;
                if (rd[i] == s.rs2) r.rs2v = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/issue_bank_rank.sv
// Orders the non-full issue banks by ascending occupancy (lower index wins ties) and
// reports, per rank, a one-hot bank select plus the number of usable banks.
module issue_bank_rank #(
    parameter  int unsigned BANK_NUM   = 2,
    parameter  int unsigned NUM_WIDTH  = 4,
    localparam int unsigned RANK_WIDTH = $clog2(BANK_NUM) + 1
) (
    input  logic [BANK_NUM-1:0]                bank_full,
    input  logic [BANK_NUM-1:0][NUM_WIDTH-1:0] bank_num,
    output logic [BANK_NUM-1:0][BANK_NUM-1:0]  rank_sel,
    output logic [RANK_WIDTH-1:0]              k
);

    logic [BANK_NUM-1:0][RANK_WIDTH-1:0] rank;

    // A bank's rank is the count of usable banks that sort ahead of it.
    always_comb begin
        rank     = '0;
        rank_sel = '0;
        k        = '0;
        for (int b = 0; b < BANK_NUM; b++) begin
            if (!bank_full[b]) k = k + RANK_WIDTH'(1);
            for (int j = 0; j < BANK_NUM; j++) begin
                if (!bank_full[j] &&
                    ((bank_num[j] < bank_num[b]) || ((bank_num[j] == bank_num[b]) && (j < b))))
                    rank[b] = rank[b] + RANK_WIDTH'(1);
            end
            for (int r = 0; r < BANK_NUM; r++) begin
                if (!bank_full[b] && (rank[b] == RANK_WIDTH'(r))) rank_sel[r][b] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/issue_dispatch_queue.sv
// In-order staging queue between dispatch and the issue banks: compacting enqueue, ranked
// multi-bank dequeue, wakeup snooping and redirect truncation.
module issue_dispatch_queue
    import issue_dispatch_queue_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH     = ISSUE_DATA_WIDTH,
    parameter  int unsigned BANK_NUM       = 2,
    parameter  int unsigned BANK_DEPTH     = 8,
    parameter  int unsigned QUEUE_DEPTH    = 8,
    parameter  int unsigned DISPATCH_WIDTH = 2,
    localparam int unsigned NUM_WIDTH      = $clog2(BANK_DEPTH) + 1
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic          [DISPATCH_WIDTH-1:0]     dis_en,
    input  issue_status_t [DISPATCH_WIDTH-1:0]     dis_status,
    input  logic [DISPATCH_WIDTH-1:0][DATA_WIDTH-1:0] dis_data,
    output logic                                   dis_ready,
    output logic          [BANK_NUM-1:0]           bank_en,
    output issue_status_t [BANK_NUM-1:0]           bank_status,
    output logic [BANK_NUM-1:0][DATA_WIDTH-1:0]    bank_data,
    input  logic          [BANK_NUM-1:0]           bank_full,
    input  logic [BANK_NUM-1:0][NUM_WIDTH-1:0]     bank_num,
    input  logic          [WB_SIZE-1:0]            wakeup_en,
    input  logic          [WB_SIZE-1:0]            wakeup_we,
    input  logic [WB_SIZE-1:0][PREG_WIDTH-1:0]     wakeup_rd,
    input  logic                                   redirect,
    input  rob_idx_t                               redirect_idx
);

    localparam int unsigned PTR_W  = $clog2(QUEUE_DEPTH) + 1;
    localparam int unsigned IDX_W  = PTR_W - 1;
    localparam int unsigned RANK_W = $clog2(BANK_NUM) + 1;

    issue_queue_entry_t mem [QUEUE_DEPTH];

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W-1:0] count;
    logic [PTR_W-1:0] enq_n;
    logic [PTR_W-1:0] deq_n;
    logic [PTR_W-1:0] trunc_ptr;
    logic             trunc_hit;
    logic             enq_fire;

    logic [DISPATCH_WIDTH-1:0][PTR_W-1:0] slot_off;
    logic [BANK_NUM-1:0][BANK_NUM-1:0]    rank_sel;
    logic [RANK_W-1:0]                    k;

    issue_bank_rank #(
        .BANK_NUM  (BANK_NUM),
        .NUM_WIDTH (NUM_WIDTH)
    ) u_rank (
        .bank_full (bank_full),
        .bank_num  (bank_num),
        .rank_sel  (rank_sel),
        .k         (k)
    );

    assign count     = tail - head;
    assign dis_ready = (count <= PTR_W'(QUEUE_DEPTH - DISPATCH_WIDTH));
    assign enq_fire  = dis_ready && !redirect;

    // Compaction: each valid slot lands after all lower-numbered valid slots.
    always_comb begin
        enq_n    = '0;
        slot_off = '0;
        for (int s = 0; s < DISPATCH_WIDTH; s++) begin
            slot_off[s] = enq_n;
            if (dis_en[s]) enq_n = enq_n + PTR_W'(1);
        end
    end

    // Entry head+r goes to the bank of rank r, with same-cycle wakeups folded in.
    always_comb begin
        issue_queue_entry_t ent;
        ent         = '0;
        bank_en     = '0;
        bank_status = '0;
        bank_data   = '0;
        deq_n       = PTR_W'(k);
        if (count < deq_n) deq_n = count;
        if (deq_n > PTR_W'(BANK_NUM)) deq_n = PTR_W'(BANK_NUM);
        if (redirect) deq_n = '0;
        for (int r = 0; r < BANK_NUM; r++) begin
            if (PTR_W'(r) < deq_n) begin
                ent = mem[IDX_W'(head + PTR_W'(r))];
                for (int b = 0; b < BANK_NUM; b++) begin
                    if (rank_sel[r][b]) begin
                        bank_en[b]     = 1'b1;
                        bank_status[b] = apply_wakeup(ent.status, wakeup_en, wakeup_we, wakeup_rd);
                        bank_data[b]   = DATA_WIDTH'(ent.data);
                    end
                end
            end
        end
    end

    // Redirect point: first entry from head that is not older than redirect_idx.
    always_comb begin
        trunc_hit = 1'b0;
        trunc_ptr = tail;
        for (int i = 0; i < QUEUE_DEPTH; i++) begin
            if (!trunc_hit && (PTR_W'(i) < count) &&
                !is_older(mem[IDX_W'(head + PTR_W'(i))].status.rob_idx, redirect_idx)) begin
                trunc_hit = 1'b1;
                trunc_ptr = head + PTR_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head <= '0;
            tail <= '0;
            for (int i = 0; i < QUEUE_DEPTH; i++) mem[i] <= '0;
        end else begin
            for (int i = 0; i < QUEUE_DEPTH; i++)
                mem[i].status <= apply_wakeup(mem[i].status, wakeup_en, wakeup_we, wakeup_rd);
            if (redirect) begin
                tail <= trunc_ptr;
            end else begin
                head <= head + deq_n;
                if (enq_fire) begin
                    tail <= tail + enq_n;
                    for (int s = 0; s < DISPATCH_WIDTH; s++) begin
                        if (dis_en[s])
                            mem[IDX_W'(tail + slot_off[s])] <= '{
                                status: apply_wakeup(dis_status[s], wakeup_en, wakeup_we, wakeup_rd),
                                data:   ISSUE_DATA_WIDTH'(dis_data[s])
                            };
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_issue_dispatch_queue.sv
// Bench for issue_dispatch_queue: directed scenarios plus random traffic against a
// queue-based reference model of the staging queue.
module tb_issue_dispatch_queue;
    import issue_dispatch_queue_pkg::*;

    localparam int unsigned DW = 2;
    localparam int unsigned BN = 2;
    localparam int unsigned QD = 8;
    localparam int unsigned NW = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic          [DW-1:0]        dis_en;
    issue_status_t [DW-1:0]        dis_status;
    logic [DW-1:0][31:0]           dis_data;
    logic                          dis_ready;
    logic          [BN-1:0]        bank_en;
    issue_status_t [BN-1:0]        bank_status;
    logic [BN-1:0][31:0]           bank_data;
    logic          [BN-1:0]        bank_full;
    logic [BN-1:0][NW-1:0]         bank_num;
    logic [WB_SIZE-1:0]            wakeup_en;
    logic [WB_SIZE-1:0]            wakeup_we;
    logic [WB_SIZE-1:0][PREG_WIDTH-1:0] wakeup_rd;
    logic                          redirect;
    rob_idx_t                      redirect_idx;

    int total = 0;
    int bad   = 0;
    issue_queue_entry_t q[$];
    logic [5:0]    rob_ctr;
    logic [5:0]    base;
    logic [BN-1:0] obs_en;
    issue_status_t obs_st [BN];

    issue_dispatch_queue dut (
        .clk          (clk),
        .rst          (rst),
        .dis_en       (dis_en),
        .dis_status   (dis_status),
        .dis_data     (dis_data),
        .dis_ready    (dis_ready),
        .bank_en      (bank_en),
        .bank_status  (bank_status),
        .bank_data    (bank_data),
        .bank_full    (bank_full),
        .bank_num     (bank_num),
        .wakeup_en    (wakeup_en),
        .wakeup_we    (wakeup_we),
        .wakeup_rd    (wakeup_rd),
        .redirect     (redirect),
        .redirect_idx (redirect_idx)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (rst && (|dis_en) && !dis_ready) $error("protocol violation: dis_en while dis_ready=0");

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic issue_status_t wake(issue_status_t s);
        for (int w = 0; w < WB_SIZE; w++) begin
            if (wakeup_en[w] && wakeup_we[w]) begin
                if (wakeup_rd[w] == s.rs1) s.rs1v = 1'b1;
                if (wakeup_rd[w] == s.rs2) s.rs2v = 1'b1;
            end
        end
        return s;
    endfunction

    // Older iff the redirect point is 1..32 steps ahead on the 64-position ROB ring.
    function automatic bit older(rob_idx_t e, rob_idx_t p);
        logic [5:0] ev, pv, d;
        ev = e;
        pv = p;
        d  = pv - ev;
        return (d >= 6'd1) && (d <= 6'd32);
    endfunction

    task automatic drive(logic [DW-1:0] en);
        int off;
        off    = 0;
        dis_en = en;
        for (int s = 0; s < DW; s++) begin
            dis_status[s].rs1     = PREG_WIDTH'($urandom_range(0, 7));
            dis_status[s].rs1v    = 1'($urandom);
            dis_status[s].rs2     = PREG_WIDTH'($urandom_range(0, 7));
            dis_status[s].rs2v    = 1'($urandom);
            dis_status[s].rd      = PREG_WIDTH'($urandom);
            dis_status[s].we      = 1'($urandom);
            dis_status[s].rob_idx = rob_idx_t'(rob_ctr + 6'(off));
            dis_data[s]           = $urandom;
            if (en[s]) off++;
        end
    endtask

    // One clock: check outputs against the model mid-cycle, then advance the model at the edge.
    task automatic cycle();
        int            order[$];
        bit            used [BN];
        int            n;
        int            f;
        int            best;
        bit            exp_ready;
        logic [BN-1:0] exp_en;
        #1;
        exp_ready = (q.size() <= QD - DW);
        check("dis_ready", 64'(dis_ready), 64'(exp_ready));
        check("count", 64'(4'(dut.tail - dut.head)), 64'(q.size()));
        for (int b = 0; b < BN; b++) used[b] = 1'b0;
        for (int r = 0; r < BN; r++) begin
            best = -1;
            for (int b = 0; b < BN; b++)
                if (!bank_full[b] && !used[b] && (best < 0 || bank_num[b] < bank_num[best])) best = b;
            if (best >= 0) begin
                used[best] = 1'b1;
                order.push_back(best);
            end
        end
        n = redirect ? 0 : order.size();
        if (n > q.size()) n = q.size();
        exp_en = '0;
        for (int r = 0; r < n; r++) begin
            int b = order[r];
            exp_en[b] = 1'b1;
            check("bank_status", 64'(bank_status[b]), 64'(wake(q[r].status)));
            check("bank_data", 64'(bank_data[b]), 64'(q[r].data));
        end
        check("bank_en", 64'(bank_en), 64'(exp_en));
        obs_en = bank_en;
        for (int b = 0; b < BN; b++) obs_st[b] = bank_status[b];
        @(posedge clk);
        if (redirect) begin
            f = q.size();
            for (int i = 0; i < q.size(); i++)
                if (!older(q[i].status.rob_idx, redirect_idx)) begin
                    f = i;
                    break;
                end
            while (q.size() > f) void'(q.pop_back());
            rob_ctr = redirect_idx;
        end else begin
            repeat (n) void'(q.pop_front());
        end
        foreach (q[i]) q[i].status = wake(q[i].status);
        if (!redirect && exp_ready)
            for (int s = 0; s < DW; s++)
                if (dis_en[s]) begin
                    q.push_back('{status: wake(dis_status[s]), data: dis_data[s]});
                    rob_ctr++;
                end
        @(negedge clk);
    endtask

    initial begin
        dis_en = '0; dis_status = '0; dis_data = '0;
        bank_full = '0; bank_num = '0;
        wakeup_en = '0; wakeup_we = '0; wakeup_rd = '0;
        redirect = 1'b0; redirect_idx = '0; rob_ctr = '0;
        #12;
        check("rst_ready", 64'(dis_ready), 64'(1));
        check("rst_bank_en", 64'(bank_en), 64'(0));
        check("rst_head", 64'(dut.head), 64'(0));
        check("rst_tail", 64'(dut.tail), 64'(0));
        @(negedge clk);
        rst = 1'b1;

        // Two-wide group, both banks empty: one per bank next cycle.
        drive(2'b11); cycle();
        drive(2'b00); cycle();
        check("t1_bank_en", 64'(obs_en), 64'(2'b11));
        check("t1_bank0_rob", 64'(obs_st[0].rob_idx), 64'(0));
        check("t1_bank1_rob", 64'(obs_st[1].rob_idx), 64'(1));
        cycle();

        // Least-occupied bank wins; a full bank is skipped.
        bank_num[1] = 4'd2; bank_num[0] = 4'd5;
        drive(2'b01); cycle();
        drive(2'b00); cycle();
        check("t2_low_num", 64'(obs_en), 64'(2'b10));
        bank_full = 2'b10;
        drive(2'b10); cycle();
        drive(2'b00); cycle();
        check("t2_full_skip", 64'(obs_en), 64'(2'b01));

        // Fill with both banks full, then drain through bank0 only.
        bank_full = 2'b11; bank_num = '0;
        base = rob_ctr;
        repeat (4) begin drive(2'b11); cycle(); end
        drive(2'b00);
        repeat (2) cycle();
        check("t3_not_ready", 64'(dis_ready), 64'(0));
        check("t3_stalled", 64'(obs_en), 64'(0));
        bank_full = 2'b10;
        for (int i = 0; i < 8; i++) begin
            cycle();
            check("t3_single_bank", 64'(obs_en), 64'(2'b01));
            check("t3_order", 64'(obs_st[0].rob_idx), 64'(6'(base + 6'(i))));
        end

        // Queue 3,4,5,6 then redirect at 5.
        rob_ctr = 6'd3; bank_full = 2'b11;
        repeat (2) begin drive(2'b11); cycle(); end
        drive(2'b00);
        bank_full = 2'b00; redirect = 1'b1; redirect_idx = rob_idx_t'(6'd5);
        cycle();
        check("t4_redirect_en", 64'(obs_en), 64'(0));
        redirect = 1'b0;
        check("t4_trunc_count", 64'(4'(dut.tail - dut.head)), 64'(2));
        cycle();
        check("t4_drain_en", 64'(obs_en), 64'(2'b11));
        check("t4_rob3", 64'(obs_st[0].rob_idx), 64'(3));
        check("t4_rob4", 64'(obs_st[1].rob_idx), 64'(4));

        // Wakeup arriving in the same cycle as the bank write.
        bank_full = 2'b11;
        drive(2'b01);
        dis_status[0].rs1 = PREG_WIDTH'(17); dis_status[0].rs1v = 1'b0;
        dis_status[0].rs2 = PREG_WIDTH'(40); dis_status[0].rs2v = 1'b0;
        cycle();
        drive(2'b00);
        bank_full = 2'b10;
        wakeup_en = 2'b01; wakeup_we = 2'b01; wakeup_rd[0] = PREG_WIDTH'(17);
        cycle();
        check("t5_rs1v", 64'(obs_st[0].rs1v), 64'(1));
        check("t5_rs2v", 64'(obs_st[0].rs2v), 64'(0));
        wakeup_en = '0; wakeup_we = '0;

        // Continuous 2-in/2-out traffic across pointer wrap.
        bank_full = 2'b00; bank_num = '0;
        repeat (20) begin drive(2'b11); cycle(); end
        drive(2'b00);
        repeat (2) cycle();

        // Random traffic against the model.
        for (int c = 0; c < 400; c++) begin
            bank_full   = 2'($urandom);
            bank_num[0] = 4'($urandom_range(0, 8));
            bank_num[1] = 4'($urandom_range(0, 8));
            wakeup_en   = 2'($urandom);
            wakeup_we   = 2'($urandom);
            for (int w = 0; w < WB_SIZE; w++) wakeup_rd[w] = PREG_WIDTH'($urandom_range(0, 7));
            redirect = ($urandom_range(0, 15) == 0);
            if (q.size() > 0) redirect_idx = q[$urandom_range(0, q.size() - 1)].status.rob_idx;
            else              redirect_idx = rob_idx_t'(rob_ctr);
            drive((q.size() <= QD - DW) ? 2'($urandom) : 2'b00);
            cycle();
        end
        redirect = 1'b0; wakeup_en = '0; wakeup_we = '0;

        // Asynchronous reset in the middle of a clock phase.
        bank_full = 2'b11;
        drive(2'b11); cycle();
        drive(2'b00);
        #2 rst = 1'b0;
        #1;
        check("arst_head", 64'(dut.head), 64'(0));
        check("arst_tail", 64'(dut.tail), 64'(0));
        check("arst_ready", 64'(dis_ready), 64'(1));
        check("arst_bank_en", 64'(bank_en), 64'(0));
        q.delete();
        rob_ctr = '0;
        @(negedge clk);
        rst = 1'b1;
        cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
